// File: rtl/pulse_handshake_crossing_pkg.sv
// pulse_handshake_crossing_pkg: shared CDC constants for the pulse handshake crossing
package pulse_handshake_crossing_pkg;
  localparam int CDC_SYNC_STAGES = 2;
endpackage

// File: rtl/pulse_handshake_crossing_sync_bit.sv
// pulse_handshake_crossing_sync_bit: reset-clearable single-bit synchronizer chain
// Ports: clk (destination clock), reset (sync, active-high), i_d (async input), o_q (synchronized output)
module pulse_handshake_crossing_sync_bit
  import pulse_handshake_crossing_pkg::*;
#(
  parameter int STAGES = CDC_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk)
    r_chain <= reset ? '0 : {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/pulse_handshake_crossing.sv
// pulse_handshake_crossing: toggle req/ack handshake carrying a pulse plus data word from clk_src to clk_dst
// Ports: clk_src/clk_dst clocks; reset sync active-high on both clocks;
//   src_pulse/src_data request, src_ready idle, src_done completion, src_drop_count rejected pulses (clk_src);
//   dst_pulse/dst_data delivered event and payload (clk_dst)
module pulse_handshake_crossing
  import pulse_handshake_crossing_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                  clk_src,
  input  logic                  reset,
  input  logic                  clk_dst,
  input  logic                  src_pulse,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  src_done,
  output logic [DROP_WIDTH-1:0] src_drop_count,
  output logic                  dst_pulse,
  output logic [DATA_WIDTH-1:0] dst_data
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  logic [0:0]            r_state;
  logic                  r_req_tgl;
  logic                  r_ack_tgl;
  logic                  r_req_prev;
  logic                  r_done;
  logic                  r_dst_pulse;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [DATA_WIDTH-1:0] r_dst_data;
  logic [DROP_WIDTH-1:0] r_drop_count;
  logic                  w_req_sync;
  logic                  w_ack_sync;
  pulse_handshake_crossing_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk(clk_dst), .reset(reset), .i_d(r_req_tgl), .o_q(w_req_sync)
  );
  pulse_handshake_crossing_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk_src), .reset(reset), .i_d(r_ack_tgl), .o_q(w_ack_sync)
  );
  // r_hold_data only changes in IDLE, i.e. while req and ack agree, so the
  // destination may sample it directly once it has seen the req toggle.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_tgl    <= 1'b0;
      r_hold_data  <= '0;
      r_done       <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (src_pulse) begin
          r_hold_data <= src_data;
          r_req_tgl   <= ~r_req_tgl;
          r_state     <= S_WAIT;
        end
      end else if (w_ack_sync == r_req_tgl) begin
        r_done  <= 1'b1;
        r_state <= S_IDLE;
      end
      if (src_pulse && r_state != S_IDLE && r_drop_count != '1)
        r_drop_count <= r_drop_count + 1'b1;
    end
  end
  always_ff @(posedge clk_dst) begin
    if (reset) begin
      r_req_prev  <= 1'b0;
      r_dst_pulse <= 1'b0;
      r_dst_data  <= '0;
      r_ack_tgl   <= 1'b0;
    end else begin
      r_req_prev  <= w_req_sync;
      r_dst_pulse <= w_req_sync != r_req_prev;
      if (w_req_sync != r_req_prev) begin
        r_dst_data <= r_hold_data;
        r_ack_tgl  <= w_req_sync;
      end
    end
  end
  assign src_ready      = r_state == S_IDLE;
  assign src_done       = r_done;
  assign src_drop_count = r_drop_count;
  assign dst_pulse      = r_dst_pulse;
  assign dst_data       = r_dst_data;
endmodule

// File: tb/tb_pulse_handshake_crossing.sv
// tb_pulse_handshake_crossing: directed self-checking bench for pulse_handshake_crossing
module tb_pulse_handshake_crossing;
  logic       clk_src = 1'b0;
  logic       clk_dst = 1'b0;
  logic       reset = 1'b1;
  logic       src_pulse = 1'b0;
  logic [7:0] src_data = '0;
  logic       src_ready, src_done, dst_pulse;
  logic [7:0] src_drop_count, dst_data;
  logic       u2_ready, u2_done, u2_dst_pulse;
  logic [1:0] u2_drop;
  logic [7:0] u2_dst_data;
  int half_src = 5;
  int half_dst = 20;
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] dst_log[$];
  always #(half_src) clk_src = ~clk_src;
  always #(half_dst) clk_dst = ~clk_dst;
  pulse_handshake_crossing u_dut (
    .clk_src(clk_src), .reset(reset), .clk_dst(clk_dst),
    .src_pulse(src_pulse), .src_data(src_data), .src_ready(src_ready),
    .src_done(src_done), .src_drop_count(src_drop_count),
    .dst_pulse(dst_pulse), .dst_data(dst_data)
  );
  pulse_handshake_crossing #(.DROP_WIDTH(2)) u_sat (
    .clk_src(clk_src), .reset(reset), .clk_dst(clk_dst),
    .src_pulse(src_pulse), .src_data(src_data), .src_ready(u2_ready),
    .src_done(u2_done), .src_drop_count(u2_drop),
    .dst_pulse(u2_dst_pulse), .dst_data(u2_dst_data)
  );
  always @(negedge clk_dst) if (dst_pulse) dst_log.push_back(dst_data);
  always @(negedge clk_src) if (src_done) done_cnt++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic [7:0] d, input int n);
    src_pulse = 1'b1;
    src_data  = d;
    repeat (n) @(negedge clk_src);
    src_pulse = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int k = 0;
    while (!src_ready && k < 400) begin
      @(negedge clk_src);
      k++;
    end
    check(tag, {31'd0, src_ready}, 32'd1);
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk_src);
  endtask
  initial begin
    int dbase, cbase, k;
    repeat (8) @(negedge clk_dst);
    @(negedge clk_src);
    check("rst_ready", {31'd0, src_ready}, 32'd1);
    check("rst_done", {31'd0, src_done}, 32'd0);
    check("rst_drop", {24'd0, src_drop_count}, 32'd0);
    check("rst_dst_pulse", {31'd0, dst_pulse}, 32'd0);
    check("rst_dst_data", {24'd0, dst_data}, 32'd0);
    reset = 1'b0;
    settle(3);
    // single event, fast source / slow destination
    dbase = dst_log.size(); cbase = done_cnt;
    pulse(8'hA5, 1);
    check("t1_busy", {31'd0, src_ready}, 32'd0);
    wait_ready("t1_ready");
    check("t1_done_with_ready", {31'd0, src_done}, 32'd1);
    settle(60);
    check("t1_dst_cnt", dst_log.size() - dbase, 32'd1);
    check("t1_dst_data", {24'd0, dst_log[dbase]}, 32'hA5);
    check("t1_done_cnt", done_cnt - cbase, 32'd1);
    check("t1_drop", {24'd0, src_drop_count}, 32'd0);
    // three pulses two cycles apart: only the first is carried
    dbase = dst_log.size(); cbase = done_cnt;
    pulse(8'h11, 1); settle(1);
    pulse(8'h22, 1); settle(1);
    pulse(8'h33, 1);
    wait_ready("t2_ready");
    settle(60);
    check("t2_dst_cnt", dst_log.size() - dbase, 32'd1);
    check("t2_dst_data", {24'd0, dst_log[dbase]}, 32'h11);
    check("t2_drop", {24'd0, src_drop_count}, 32'd2);
    check("t2_done_cnt", done_cnt - cbase, 32'd1);
    // pulse held 7 cycles: one accept, six drops; 2-bit counter saturates
    dbase = dst_log.size();
    pulse(8'h44, 7);
    wait_ready("t4_ready");
    settle(60);
    check("t4_dst_cnt", dst_log.size() - dbase, 32'd1);
    check("t4_dst_data", {24'd0, dst_log[dbase]}, 32'h44);
    check("t4_drop8", {24'd0, src_drop_count}, 32'd8);
    check("t4_drop2_sat", {30'd0, u2_drop}, 32'd3);
    // pulse coincident with the ack detection cycle is dropped
    dbase = dst_log.size(); cbase = done_cnt;
    pulse(8'h5A, 1);
    k = 0;
    while (!(u_dut.w_ack_sync == u_dut.r_req_tgl && !src_ready) && k < 400) begin
      @(negedge clk_src);
      k++;
    end
    check("t6_detect_seen", {31'd0, k < 400}, 32'd1);
    pulse(8'hEE, 1);
    check("t6_done", {31'd0, src_done}, 32'd1);
    check("t6_drop", {24'd0, src_drop_count}, 32'd9);
    settle(80);
    check("t6_dst_cnt", dst_log.size() - dbase, 32'd1);
    check("t6_dst_data", {24'd0, dst_log[dbase]}, 32'h5A);
    check("t6_done_cnt", done_cnt - cbase, 32'd1);
    check("t6_ready", {31'd0, src_ready}, 32'd1);
    // slow source / fast destination, back-to-back events 1..10
    half_src = 20; half_dst = 5;
    settle(4);
    dbase = dst_log.size(); cbase = done_cnt;
    for (int i = 1; i <= 10; i++) begin
      wait_ready("t3_ready");
      pulse(8'(i), 1);
    end
    wait_ready("t3_ready_end");
    settle(20);
    check("t3_dst_cnt", dst_log.size() - dbase, 32'd10);
    for (int i = 0; i < 10; i++)
      check("t3_order", {24'd0, dst_log[dbase + i]}, 32'(i + 1));
    check("t3_done_cnt", done_cnt - cbase, 32'd10);
    check("t3_drop", {24'd0, src_drop_count}, 32'd9);
    // reset one cycle after the req toggle abandons the transfer
    half_src = 5; half_dst = 20;
    settle(4);
    dbase = dst_log.size(); cbase = done_cnt;
    pulse(8'h77, 1);
    reset = 1'b1;
    repeat (6) @(negedge clk_dst);
    @(negedge clk_src);
    reset = 1'b0;
    settle(150);
    check("t5_no_dst", dst_log.size() - dbase, 32'd0);
    check("t5_no_done", done_cnt - cbase, 32'd0);
    check("t5_ready", {31'd0, src_ready}, 32'd1);
    check("t5_drop_clr", {24'd0, src_drop_count}, 32'd0);
    check("t5_dst_data_clr", {24'd0, dst_data}, 32'd0);
    pulse(8'h3C, 1);
    wait_ready("t5_ready2");
    settle(60);
    check("t5_dst_cnt", dst_log.size() - dbase, 32'd1);
    check("t5_dst_data", {24'd0, dst_data}, 32'h3C);
    check("t5_done_cnt", done_cnt - cbase, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
